// File: rtl/branch_operand_feeder_pkg.sv
// -----------------------------------------------------------------------------
// branch_feeder_pkg
// Shared types and helpers for the ID-stage branch operand feeder.
//   - default operand / register index widths
//   - FSM state encoding
//   - hazard_need(): how many stall cycles a source register still requires
//     before its producer's value can be forwarded into ID.
// -----------------------------------------------------------------------------
package branch_feeder_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int NEED_W         = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESOLVE
    } state_t;

    // Stall requirement for one source register. A source only conflicts with
    // a producer when it is nonzero ($0 is hardwired) and names the producer's
    // destination. The first matching rule wins.
    function automatic logic [NEED_W-1:0] hazard_need(
        input logic [DEF_REG_ADDR_W-1:0] addr,
        input logic                      ex_reg_write,
        input logic                      ex_mem_read,
        input logic [DEF_REG_ADDR_W-1:0] ex_dst,
        input logic                      mem_reg_write,
        input logic                      mem_mem_read,
        input logic [DEF_REG_ADDR_W-1:0] mem_dst
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (addr != '0) && (addr == ex_dst);
        mem_hit = (addr != '0) && (addr == mem_dst);
        if (ex_reg_write && ex_mem_read && ex_hit)
            return NEED_W'(2);
        else if (ex_reg_write && !ex_mem_read && ex_hit)
            return NEED_W'(1);
        else if (mem_reg_write && mem_mem_read && mem_hit)
            return NEED_W'(1);
        else
            return NEED_W'(0);
    endfunction

endpackage

// File: rtl/branch_operand_feeder_eq_cmp.sv
// -----------------------------------------------------------------------------
// branch_eq_cmp
// Full-width bitwise equality of the two captured branch operands.
// Ports:
//   op_a, op_b  in  DATA_W  registered branch operands
//   eq          out 1       1 when op_a and op_b are identical
// -----------------------------------------------------------------------------
module branch_eq_cmp
    import branch_feeder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              eq
);

    assign eq = (op_a == op_b);

endmodule

// File: rtl/branch_operand_feeder.sv
// -----------------------------------------------------------------------------
// branch_operand_feeder
// Feeds the two source operands of a BEQ/BNE in ID, stalls ID while a RAW
// hazard against EX/MEM cannot yet be forwarded, and resolves the branch one
// cycle after the operands are captured.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   br_valid, br_is_bne        ID holds a branch / branch is BNE
//   rs_addr, rt_addr           branch source registers
//   rs_rf_data, rt_rf_data     register-file read data
//   ex_reg_write, ex_mem_read, ex_dst        EX-stage producer
//   mem_reg_write, mem_mem_read, mem_dst,
//   mem_alu_result                           MEM-stage producer
//   wb_reg_write, wb_dst, wb_data            WB-stage producer
//   br_ready                   block can accept a branch (IDLE)
//   stall_id                   freeze PC and IF/ID, bubble into EX
//   br_done                    one-cycle outcome pulse
//   br_taken                   outcome, valid with br_done
//   flush_if                   br_done & br_taken
//   stat_branches, stat_taken, stat_stall_cycles
//                              statistics counters
//
// Build option: define BRANCH_FEEDER_STATS_EN to enable the statistics
// counters; otherwise the stat outputs are constant 0.
// -----------------------------------------------------------------------------
module branch_operand_feeder
    import branch_feeder_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  br_valid,
    input  logic                  br_is_bne,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     rs_rf_data,
    input  logic [DATA_W-1:0]     rt_rf_data,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  br_ready,
    output logic                  stall_id,
    output logic                  br_done,
    output logic                  br_taken,
    output logic                  flush_if,
    output logic [STAT_W-1:0]     stat_branches,
    output logic [STAT_W-1:0]     stat_taken,
    output logic [STAT_W-1:0]     stat_stall_cycles
);

    state_t                state;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  is_bne;
    logic [REG_ADDR_W-1:0] lat_rs;
    logic [REG_ADDR_W-1:0] lat_rt;

    logic [REG_ADDR_W-1:0] cur_rs;
    logic [REG_ADDR_W-1:0] cur_rt;
    logic [NEED_W-1:0]     need_rs;
    logic [NEED_W-1:0]     need_rt;
    logic [NEED_W-1:0]     need;
    logic [DATA_W-1:0]     sel_a;
    logic [DATA_W-1:0]     sel_b;
    logic                  eq;
    logic                  resolve_taken;

    // Forwarding mux for one source; MEM ALU result beats WB, WB beats the RF.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     rf_data
    );
        if (addr == '0)
            return '0;
        else if (mem_reg_write && !mem_mem_read && (addr == mem_dst))
            return mem_alu_result;
        else if (wb_reg_write && (wb_dst == addr))
            return wb_data;
        else
            return rf_data;
    endfunction

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        // While waiting, IF/ID is frozen but the hazard is tracked against the
        // addresses captured at acceptance.
        cur_rs  = (state == WAIT) ? lat_rs : rs_addr;
        cur_rt  = (state == WAIT) ? lat_rt : rt_addr;
        need_rs = hazard_need(cur_rs, ex_reg_write, ex_mem_read, ex_dst,
                              mem_reg_write, mem_mem_read, mem_dst);
        need_rt = hazard_need(cur_rt, ex_reg_write, ex_mem_read, ex_dst,
                              mem_reg_write, mem_mem_read, mem_dst);
        need    = (need_rs > need_rt) ? need_rs : need_rt;
        sel_a   = select_operand(cur_rs, rs_rf_data);
        sel_b   = select_operand(cur_rt, rt_rf_data);
    end

    branch_eq_cmp #(
        .DATA_W (DATA_W)
    ) u_eq_cmp (
        .op_a (op_a),
        .op_b (op_b),
        .eq   (eq)
    );

    assign resolve_taken = eq ^ is_bne;
    assign br_ready      = (state == IDLE);
    assign br_done       = (state == RESOLVE);
    // Gated so the outcome reads 0 outside the br_done pulse.
    assign br_taken      = br_done & resolve_taken;
    assign flush_if      = br_taken;

    always_comb begin
        stall_id = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE:    stall_id = br_valid && (need != '0);
                WAIT:    stall_id = (need != '0);
                // A taken branch flushes the following instruction anyway.
                RESOLVE: stall_id = br_valid && !resolve_taken;
                default: stall_id = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            is_bne <= 1'b0;
            lat_rs <= '0;
            lat_rt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (br_valid) begin
                        is_bne <= br_is_bne;
                        if (need == '0) begin
                            op_a  <= sel_a;
                            op_b  <= sel_b;
                            state <= RESOLVE;
                        end else begin
                            lat_rs <= rs_addr;
                            lat_rt <= rt_addr;
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (need == '0) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        state <= RESOLVE;
                    end
                end
                RESOLVE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_FEEDER_STATS_EN
    logic [STAT_W-1:0] cnt_branches;
    logic [STAT_W-1:0] cnt_taken;
    logic [STAT_W-1:0] cnt_stall;

    // Counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_branches <= '0;
            cnt_taken    <= '0;
            cnt_stall    <= '0;
        end else begin
            if (br_done)
                cnt_branches <= cnt_branches + 1'b1;
            if (br_done && br_taken)
                cnt_taken <= cnt_taken + 1'b1;
            if (stall_id)
                cnt_stall <= cnt_stall + 1'b1;
        end
    end

    assign stat_branches     = cnt_branches;
    assign stat_taken        = cnt_taken;
    assign stat_stall_cycles = cnt_stall;
`else
    assign stat_branches     = '0;
    assign stat_taken        = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule
